// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus iterative shift-add
// multiply and restoring unsigned divide/remainder, behind valid/ready on
// both the operand side and the result side. One op in flight at a time.
module alu_mc #(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] o,
  output logic             zero,
  output logic             busy
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_NOT  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_SRL  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_XOR  = 4'b1010;
  localparam logic [3:0] OP_MUL  = 4'b1011;
  localparam logic [3:0] OP_DIVU = 4'b1100;
  localparam logic [3:0] OP_REMU = 4'b1101;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [3:0]       op_q;
  // mul: opa = shifted multiplicand, opb = shifted multiplier, acc = product
  // div: opa = dividend shifting out / quotient shifting in, opb = divisor,
  //      acc = partial remainder (one extra bit for the trial compare)
  logic [WIDTH-1:0] opa, opb;
  logic [WIDTH:0]   acc;
  logic [SHW-1:0]   cnt;

  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] sc_res;
  logic             is_iter;

  logic [WIDTH-1:0] mul_acc;
  logic [WIDTH:0]   rem_sh, rem_next;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] fin;

  assign sh      = b[SHW-1:0];
  assign is_iter = (alu_ctl == OP_MUL) || (alu_ctl == OP_DIVU) || (alu_ctl == OP_REMU);

  // Single-cycle result; unused encodings fall back to add.
  always_comb begin
    sc_res = a + b;
    case (alu_ctl)
      OP_ADD:  sc_res = a + b;
      OP_SUB:  sc_res = a - b;
      OP_NOT:  sc_res = ~a;
      OP_SLL:  sc_res = a << sh;
      OP_SRL:  sc_res = a >> sh;
      OP_SRA:  sc_res = $unsigned($signed(a) >>> sh);
      OP_AND:  sc_res = a & b;
      OP_OR:   sc_res = a | b;
      OP_XOR:  sc_res = a ^ b;
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (a < b)};
      default: sc_res = a + b;
    endcase
  end

  // One multiply step and one restoring-divide step, plus the value that
  // lands in o when the current step is the last one.
  always_comb begin
    mul_acc  = acc[WIDTH-1:0] + (opb[0] ? opa : '0);
    rem_sh   = {acc[WIDTH-1:0], opa[WIDTH-1]};
    rem_next = rem_sh;
    q_next   = {opa[WIDTH-2:0], 1'b0};
    if (rem_sh >= {1'b0, opb}) begin
      rem_next = rem_sh - {1'b0, opb};
      q_next   = {opa[WIDTH-2:0], 1'b1};
    end
    case (op_q)
      OP_MUL:  fin = mul_acc;
      OP_DIVU: fin = q_next;
      default: fin = rem_next[WIDTH-1:0];
    endcase
  end

  // Control FSM with all handshake/status outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      o         <= '0;
      zero      <= 1'b1;
      busy      <= 1'b0;
      cnt       <= '0;
      op_q      <= OP_ADD;
      opa       <= '0;
      opb       <= '0;
      acc       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (is_iter) begin
              op_q  <= alu_ctl;
              opa   <= a;
              opb   <= b;
              acc   <= '0;
              cnt   <= '0;
              busy  <= 1'b1;
              state <= BUSY;
            end else begin
              o         <= sc_res;
              zero      <= (sc_res == '0);
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        BUSY: begin
          if (op_q == OP_MUL) begin
            acc <= {1'b0, mul_acc};
            opa <= opa << 1;
            opb <= opb >> 1;
          end else begin
            acc <= rem_next;
            opa <= q_next;
          end
          cnt <= cnt + SHW'(1);
          if (cnt == SHW'(WIDTH-1)) begin
            o         <= fin;
            zero      <= (fin == '0);
            busy      <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc (WIDTH=32): directed cases, backpressure, mid-op reset
// abort, then random ops checked against an arithmetic reference model.
module tb_alu_mc;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctl;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] o;
  logic        zero;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  alu_mc #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctl(alu_ctl), .a(a), .b(b), .out_valid(out_valid),
    .out_ready(out_ready), .o(o), .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: results straight from the op table using plain arithmetic.
  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    int signed   sx, sy;
    longint unsigned prod;
    sx = x; sy = y;
    case (op)
      4'd0:  return x + y;
      4'd1:  return x - y;
      4'd2:  return ~x;
      4'd3:  return x << y[4:0];
      4'd4:  return x >> y[4:0];
      4'd8:  return 32'(sx >>> y[4:0]);
      4'd5:  return x & y;
      4'd6:  return x | y;
      4'd10: return x ^ y;
      4'd7:  return (sx < sy) ? 32'd1 : 32'd0;
      4'd9:  return (x < y) ? 32'd1 : 32'd0;
      4'd11: begin prod = 64'(x) * 64'(y); return prod[31:0]; end
      4'd12: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      4'd13: return (y == 0) ? x : x % y;
      default: return x + y;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op from IDLE (called at a negedge), wait for the result,
  // optionally hold out_ready low for `hold` cycles, then complete the
  // handshake. Inputs are scrambled after acceptance.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] x,
                        input logic [31:0] y, input int hold);
    logic [31:0] exp;
    bit          iter;
    int          lat, bcnt;
    exp  = model(op, x, y);
    iter = (op == 4'd11) || (op == 4'd12) || (op == 4'd13);
    chk({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; alu_ctl = op; a = x; b = y;
    @(posedge clk); #1;
    in_valid = 1'($urandom); alu_ctl = 4'($urandom); a = $urandom; b = $urandom;
    lat = 0; bcnt = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
      if (out_valid || lat > 200) break;
      in_valid = 1'($urandom); a = $urandom; b = $urandom;
    end
    chk({tag, ".latency"}, 32'(lat), iter ? 32'd33 : 32'd1);
    chk({tag, ".busy_cycles"}, 32'(bcnt), iter ? 32'd32 : 32'd0);
    chk({tag, ".o"}, o, exp);
    chk({tag, ".zero"}, 32'(zero), 32'(exp == 0));
    chk({tag, ".in_ready_done"}, 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; a = $urandom;
      @(negedge clk);
      chk({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, ".hold_o"}, o, exp);
      chk({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ".valid_drop"}, 32'(out_valid), 32'd0);
    chk({tag, ".ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    bit seen_valid;
    logic [3:0]  rop;
    logic [31:0] rx, ry;
    rst_n = 1'b0; in_valid = 1'b0; alu_ctl = 4'd0; a = '0; b = '0; out_ready = 1'b0;
    #12;
    chk("rst.in_ready",  32'(in_ready),  32'd1);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.o",         o,              32'd0);
    chk("rst.zero",      32'(zero),      32'd1);
    chk("rst.busy",      32'(busy),      32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    run_op("sub_eq",  4'd1,  32'd5,          32'd5,          0);
    run_op("sra",     4'd8,  32'h8000_0000,  32'h24,         0);
    run_op("slt",     4'd7,  32'hFFFF_FFFF,  32'd1,          0);
    run_op("sltu",    4'd9,  32'hFFFF_FFFF,  32'd1,          0);
    run_op("mul7x6",  4'd11, 32'd7,          32'd6,          0);
    run_op("mulneg",  4'd11, 32'hFFFF_FFFF,  32'd2,          0);
    run_op("divu",    4'd12, 32'd100,        32'd7,          0);
    run_op("remu",    4'd13, 32'd100,        32'd7,          0);
    run_op("divu0",   4'd12, 32'd1234,       32'd0,          0);
    run_op("remu0",   4'd13, 32'd9,          32'd0,          0);
    run_op("bp_add",  4'd0,  32'hFFFF_FFFF,  32'd3,          5);
    run_op("bp_mul",  4'd11, 32'h0001_0003,  32'h0000_0105,  5);
    run_op("op15",    4'd15, 32'd40,         32'd2,          0);
    run_op("srl_hi",  4'd4,  32'hF000_0000,  32'hFFFF_FFE4,  0);

    // Abort a multiply mid-flight with an asynchronous reset pulse.
    in_valid = 1'b1; alu_ctl = 4'd11; a = 32'd123; b = 32'd456;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort.busy",      32'(busy),      32'd0);
    chk("abort.in_ready",  32'(in_ready),  32'd1);
    chk("abort.out_valid", 32'(out_valid), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    seen_valid = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen_valid = 1'b1;
    end
    chk("abort.no_valid", 32'(seen_valid), 32'd0);
    run_op("post_abort", 4'd12, 32'd1000, 32'd33, 0);

    // Random ops, biased so divides sometimes see small or zero divisors.
    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(0, 15));
      rx  = $urandom;
      ry  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      run_op($sformatf("rnd%0d_op%0d", i, rop), rop, rx, ry, int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the bench can never hang.
  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
Parametrised multi-cycle ALU and successor to the single-cycle integer ALU. It keeps the same 4-bit op encoding, adds arithmetic right shift, a true signed compare, and iterative multiply, unsigned divide and unsigned remainder. A valid/ready handshake sits on both the operand and result sides. The block sits in the execute stage; the pipeline control stalls on in_ready/out_valid.

Parameters:
WIDTH, 32, operand/result width in bits (power of two, ≥8)
SHW, $clog2(WIDTH), shift-amount bits taken from b (derived, not overridden)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands/op presented
in_ready  output  1  block can accept an op this cycle
alu_ctl  input  4  operation select
a  input  WIDTH  operand A
b  input  WIDTH  operand B
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
o  output  WIDTH  registered result
zero  output  1  o == 0, registered alongside o
busy  output  1  iterative op in progress

Behaviour:
- Clock and reset: one clock clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, o=0, zero=1, busy=0, iteration counter=0.
- Reset asserted mid-operation aborts immediately. The partial result is discarded and no out_valid follows.
- Op encoding:
  - 0000 add; 0001 sub; 0010 ~a
  - 0011 sll; 0100 srl; 1000 sra
  - 0101 and; 0110 or; 1010 xor
  - 0111 slt (signed two's-complement); 1001 sltu (unsigned)
  - 1011 mul (low WIDTH bits); 1100 divu; 1101 remu
  - 1110, 1111 execute as add.
- Shifts use b[SHW-1:0] only; upper bits of b are ignored. sra replicates a[WIDTH-1].
- add/sub wrap modulo 2^WIDTH. slt/sltu return 1 or 0, zero-extended.
- FSM: IDLE, BUSY, DONE.
  - IDLE:
    - in_ready=1.
    - in_valid with a single-cycle op: register the result into o/zero, go to DONE.
    - in_valid with mul/divu/remu: latch a, b, op; clear the accumulator and counter; busy=1; go to BUSY.
  - BUSY:
    - in_ready=0. One iteration per cycle, exactly WIDTH iterations.
    - mul: shift-add, LSB of multiplier first.
    - divu/remu: restoring division, MSB first.
    - After the last iteration: write o/zero, busy=0, go to DONE.
  - DONE:
    - out_valid=1, in_ready=0; o/zero held stable.
    - out_ready=1: out_valid drops the next cycle, go to IDLE.
    - out_ready=0: hold indefinitely.
- Latency, acceptance edge to out_valid high:
  - single-cycle ops: 1 cycle
  - mul/divu/remu: WIDTH+1 cycles
- Throughput: one op in flight. The next op is accepted at the earliest on the cycle after the DONE handshake.
- Divide by zero (b==0): divu gives all ones; remu gives a. Latency is unchanged and there is no exception.
- in_valid while in_ready=0: ignored. The producer must hold the request; operands are sampled only on the accept edge.
- Input changes during BUSY/DONE do not affect the result in progress.
- zero is computed from the final o, never from intermediate accumulator values.

Test Plan:
- Reset/idle:
  - assert rst_n=0 -> in_ready=1, out_valid=0, o=0, zero=1, busy=0.
- Single-cycle ops (WIDTH=32):
  - sub, a=5, b=5 -> o=0, zero=1, out_valid one cycle after accept.
  - sra, a=0x80000000, b=0x24 -> shift by 4, o=0xF8000000.
- Compares:
  - slt, a=0xFFFFFFFF, b=1 -> o=1.
  - sltu with same operands -> o=0.
- mul:
  - a=7, b=6 -> busy=1 for 32 cycles, o=42 with out_valid at accept+33.
  - a=0xFFFFFFFF, b=2 -> o=0xFFFFFFFE.
- Divide:
  - divu, a=100, b=7 -> o=14.
  - remu, a=100, b=7 -> o=2.
  - divu, b=0 -> o=0xFFFFFFFF.
  - remu, a=9, b=0 -> o=9.
- Backpressure and abort:
  - out_ready=0 for 5 cycles after DONE -> o and out_valid held; in_valid ignored (in_ready=0).
  - rst_n pulsed low mid-mul -> no out_valid; next op result correct.
